// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and divide, one bit per clock; done pulses N+1 cycles after the accept edge.
// No backpressure: start is taken only in IDLE, and busy tells the caller to stall.
module mul_div_unit #(
    parameter int N = 32,
    parameter int O = 2,
    parameter int C = $clog2(N)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [O-1:0] op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state, state_nxt;
    logic [C-1:0]   count;
    logic [2*N-1:0] acc;
    logic [N-1:0]   operand;
    logic           is_div, neg_q, neg_r, b_zero;

    logic           op_known, op_div, op_signed, sign_a, sign_b;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     sum, shifted;
    logic [N-1:0]   trial;
    logic [2*N-1:0] step;
    logic [N-1:0]   res_hi, res_lo;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == C'(N - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == FIX);
    end

    // Op codes above 3 fall back to MULTU.
    always_comb begin
        op_known  = 32'(op) < 32'd4;
        op_div    = op_known & op[1];
        op_signed = op_known & op[0];
        sign_a    = op_signed & inA[N-1];
        sign_b    = op_signed & inB[N-1];
        mag_a     = sign_a ? -inA : inA;
        mag_b     = sign_b ? -inB : inB;
    end

    // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        sum     = {1'b0, acc[2*N-1:N]} + {1'b0, operand};
        shifted = acc[2*N-1:N-1];
        trial   = shifted[N-1:0] - operand;
        step    = '0;
        if (is_div) begin
            if (shifted >= {1'b0, operand}) step = {trial, acc[N-2:0], 1'b1};
            else                            step = {acc[2*N-2:0], 1'b0};
        end else if (acc[0]) begin
            step = {sum, acc[N-1:1]};
        end else begin
            step = {1'b0, acc[2*N-1:1]};
        end
    end

    // A zero divisor leaves the dividend magnitude in the remainder, so only the quotient is forced.
    always_comb begin
        res_hi = acc[2*N-1:N];
        res_lo = acc[N-1:0];
        if (is_div) begin
            if (neg_r) res_hi = -acc[2*N-1:N];
            if (b_zero)     res_lo = '1;
            else if (neg_q) res_lo = -acc[N-1:0];
        end else if (neg_q) begin
            {res_hi, res_lo} = -acc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_div  <= op_div;
                    neg_q   <= sign_a ^ sign_b;
                    neg_r   <= sign_a;
                    b_zero  <= (inB == '0);
                    acc     <= {{N{1'b0}}, op_div ? mag_a : mag_b};
                    operand <= op_div ? mag_b : mag_a;
                    count   <= '0;
                    div0    <= 1'b0;
                end
                RUN: begin
                    acc   <= step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    div0 <= is_div & b_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_mul_div_unit;
    localparam int N = 32;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] inA, inB;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    mul_div_unit #(.N(N), .O(2)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0:    r = {32'b0, a} * {32'b0, b};
            2'd1:    r = 64'(sa * sb);
            2'd2:    r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
        endcase
        return r;
    endfunction

    // Reference model: an accepted op completes N+1 edges later; busy covers the edges in between.
    int          cyc = 0;
    int          m_fix = 0;
    logic        m_active = 1'b0, m_done = 1'b0, m_div0 = 1'b0, p_div0 = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_div0   <= 1'b0;
            m_hi     <= '0;
            m_lo     <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_active && cyc == m_fix) begin
                m_hi     <= p_hi;
                m_lo     <= p_lo;
                m_div0   <= p_div0;
                m_done   <= 1'b1;
                m_active <= 1'b0;
            end else if (!m_active && start) begin
                {p_hi, p_lo} <= ref_calc(op, inA, inB);
                p_div0   <= op[1] && (inB == 32'd0);
                m_fix    <= cyc + N + 1;
                m_active <= 1'b1;
                m_div0   <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("busy", 64'(busy), 64'(m_active));
            check("done", 64'(done), 64'(m_done));
            check("div0", 64'(div0), 64'(m_div0));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int bcyc, output logic first_div0);
        bit got;
        got = 1'b0;
        bcyc = 0;
        first_div0 = 1'bx;
        @(posedge clock); #1;
        start = 1'b1; op = o; inA = a; inB = b;
        @(posedge clock); #1;
        start = 1'b0; inA = $urandom; inB = $urandom; op = 2'($urandom);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i == 0) first_div0 = div0;
            if (busy) bcyc++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("op_done_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check("idle_seen", 64'(idle), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc, last, dn_cnt;
        logic d0;
        reset = 1'b1; start = 1'b0; op = '0; inA = '0; inB = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        cmp_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;

        run_op(2'd0, 32'hFFFF_FFFF, 32'h2, bc, d0);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, bc, d0);
        check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(2'd1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, bc, d0);
        check("mult_pos_hi", 64'(hi), 64'h0);
        check("mult_pos_lo", 64'(lo), 64'd21);

        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, bc, d0);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(2'd2, 32'd100, 32'd7, bc, d0);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, d0);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'h0);
        check("div_ovf_div0", 64'(div0), 64'd0);

        run_op(2'd2, 32'd5, 32'd0, bc, d0);
        check("divu0_busy_cycles", 64'(bc), 64'd33);
        check("divu0_hi", 64'(hi), 64'd5);
        check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
        check("divu0_div0", 64'(div0), 64'd1);
        run_op(2'd0, 32'd2, 32'd3, bc, d0);
        check("div0_clear_on_accept", 64'(d0), 64'd0);
        check("multu_small_lo", 64'(lo), 64'd6);
        run_op(2'd3, 32'hFFFF_FFFB, 32'd0, bc, d0);
        check("div0_signed_hi", 64'(hi), 64'hFFFF_FFFB);
        check("div0_signed_lo", 64'(lo), 64'hFFFF_FFFF);
        check("div0_signed_flag", 64'(div0), 64'd1);

        // Start held high with operands changing every cycle.
        @(posedge clock); #1;
        start = 1'b1; op = 2'($urandom); inA = $urandom; inB = $urandom;
        last = -1;
        dn_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (done) begin
                if (last >= 0) check("done_gap", 64'(i - last), 64'd34);
                last = i;
                dn_cnt++;
            end
            @(posedge clock); #1;
            op = 2'($urandom); inA = $urandom; inB = $urandom;
        end
        start = 1'b0;
        check("b2b_done_count", 64'(dn_cnt), 64'd3);
        wait_idle();

        // Reset in the middle of a divide.
        @(posedge clock); #1;
        start = 1'b1; op = 2'd2; inA = 32'd1000; inB = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        dn_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dn_cnt++;
        end
        check("abort_no_done", 64'(dn_cnt), 64'd0);
        run_op(2'd0, 32'd2, 32'd3, bc, d0);
        check("post_abort_lo", 64'(lo), 64'd6);
        check("post_abort_hi", 64'(hi), 64'd0);

        repeat (2) @(negedge clock);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the datapath: the multi-cycle successor to the single-cycle ALU.
- Performs signed/unsigned N×N multiply (2N-bit product) and signed/unsigned N/N divide (quotient + remainder), one bit per clock.
- Results land in internal HI/LO registers that hold until the next operation completes.
- Start/busy/done handshake lets the control unit stall on busy.

Parameters:
- N, 32, operand width; N >= 2.
- O, 2, op code width.
- C, $clog2(N), iteration counter width.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  O  0=MULTU, 1=MULT, 2=DIVU, 3=DIV; sampled with start.
- inA  input  N  multiplicand/dividend; sampled with start.
- inB  input  N  multiplier/divisor; sampled with start.
- busy  output  1  high while an operation is in flight (RUN, FIX).
- done  output  1  one-cycle pulse; HI/LO valid and updated.
- div0  output  1  sticky-until-next-op flag: last divide had inB==0.
- hi  output  N  product[2N-1:N] / remainder.
- lo  output  N  product[N-1:0] / quotient.

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset:
  - On a posedge with reset=1: state=IDLE, counter=0, busy=0, done=0, div0=0, hi=0, lo=0.
  - Reset overrides start and aborts any in-flight operation; no partial result is written.
- States are IDLE, RUN and FIX. busy=1 exactly when state is RUN or FIX.
- IDLE:
  - On start=1, latch op, |inA|, |inB|, sign(inA) and sign(inB). Magnitudes are used for signed ops only; unsigned ops take the raw values.
  - Clear the working accumulator, counter=0, go to RUN.
  - If start=0, remain in IDLE.
- RUN: perform one iteration per posedge, then counter++.
  - On the posedge where counter==N-1, perform the last iteration and go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2N-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle, MSB first. Trial subtract uses N+1 bits so no carry is lost.
- FIX (one posedge):
  - MULT: negate the 2N-bit product if sign(inA)^sign(inB).
  - DIV: negate the quotient if sign(inA)^sign(inB); the remainder takes sign(inA).
  - Write hi/lo, set done=1, go to IDLE.
- done:
  - High for exactly the one cycle after the FIX posedge (the first IDLE cycle); cleared on the next posedge.
  - A start asserted in that done cycle is accepted (back-to-back operation).
- Latency:
  - Start sampled at posedge t → busy=1 from t → done=1 and hi/lo valid after posedge t+N+1.
  - Throughput is one operation per N+2 cycles.
- Divide by zero (inB==0, DIVU or DIV):
  - Runs the full N+1 cycles.
  - Result is hi=inA (original, signed value), lo={N{1'b1}}, div0=1.
- div0 is cleared when the next op is accepted.
- Signed overflow: DIV with inA=most-negative and inB=-1 gives lo=most-negative, hi=0, div0=0. This falls out naturally from magnitude arithmetic; no special case.
- start, op, inA and inB are ignored while busy. Operands may change freely after the accept edge.
- hi/lo change only on the FIX posedge or on reset.
- Undefined op codes cannot occur with O=2. If O>2 and op>3: treat as MULTU.

Test Plan:
- Reset, then MULTU inA=32'hFFFF_FFFF, inB=32'h2 → done 33 cycles after the start edge; hi=32'h1, lo=32'hFFFF_FFFE; busy high for exactly 33 cycles.
- MULT inA=-3 (32'hFFFF_FFFD), inB=7 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB (-21); then MULT -3 × -7 → hi=0, lo=21.
- DIV inA=-7, inB=2 → lo=-3 (32'hFFFF_FFFD), hi=-1; DIVU 100/7 → lo=14, hi=2; DIV 32'h8000_0000 / -1 → lo=32'h8000_0000, hi=0.
- DIVU inA=5, inB=0 → hi=5, lo=32'hFFFF_FFFF, div0=1; next MULTU 2×3 → div0=0 on accept, lo=6.
- Back-to-back and ignore-while-busy:
  - Start held high continuously with changing operands → only operands present at each accept edge are used.
  - done pulses every 34 cycles, each for 1 cycle.
- Reset asserted at cycle 10 of a DIVU → next cycle busy=0, done=0, hi=lo=0; no done pulse follows; a fresh start works normally.
